// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared constants for the FIFO write-side arbiter:
//   - default FIFO word width
//   - FSM state encoding (fixed values, kept as plain constants so the encoding
//     stays stable for legacy tools and waveform decoders)
//   - requester identifiers used by the round-robin last_grant register
//   - helper that identifies states whose write completes a slot
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE        = 2'b00;
   localparam logic [1:0] ST_SEND_RF     = 2'b01;
   localparam logic [1:0] ST_SEND_ALU_LO = 2'b10;
   localparam logic [1:0] ST_SEND_ALU_HI = 2'b11;

   // Requester identifiers
   localparam logic REQ_RF  = 1'b0;
   localparam logic REQ_ALU = 1'b1;

   // True for states whose write empties a slot and therefore re-grants.
   function automatic logic is_last_byte(input logic [1:0] state);
      return (state == ST_SEND_RF) || (state == ST_SEND_ALU_HI);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester handshakes and the FIFO write port of the arbiter.
//   alu_valid/alu_data/alu_ready : ALU result offer (2*DATA_WIDTH bits)
//   rf_valid/rf_data/rf_ready    : register-file byte offer (DATA_WIDTH bits)
//   wfull                        : FIFO full flag (write domain)
//   winc/wr_data                 : FIFO write strobe and data
//   busy                         : arbiter FSM is not idle
// Modports:
//   slave  - the arbiter side (consumes offers, drives the FIFO port)
//   master - the environment side (requesters and FIFO)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic                      alu_valid;
   logic [2*DATA_WIDTH-1:0]   alu_data;
   logic                      alu_ready;
   logic                      rf_valid;
   logic [DATA_WIDTH-1:0]     rf_data;
   logic                      rf_ready;
   logic                      wfull;
   logic                      winc;
   logic [DATA_WIDTH-1:0]     wr_data;
   logic                      busy;

   modport slave (
      input  alu_valid, alu_data, rf_valid, rf_data, wfull,
      output alu_ready, rf_ready, winc, wr_data, busy
   );

   modport master (
      output alu_valid, alu_data, rf_valid, rf_data, wfull,
      input  alu_ready, rf_ready, winc, wr_data, busy
   );

endinterface

// File: rtl/fifo_req_slot.sv
// -----------------------------------------------------------------------------
// fifo_req_slot
// One-entry holding register with a valid/ready load handshake.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_valid    : data offered by the requester
//   i_data     : offered data (WIDTH bits)
//   i_clear    : empty the slot on this edge (last byte written)
//   o_ready    : slot is empty and can accept
//   o_full     : slot holds data
//   o_data     : held data
// Clearing wins over loading; since loading needs the slot empty and clearing
// only happens while it is full, the two never coincide, so a cleared slot is
// only refilled on a later edge.
// -----------------------------------------------------------------------------
module fifo_req_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_clear,
   output logic             o_ready,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (i_valid && !r_full) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end
   end

   assign o_ready = !r_full;
   assign o_full  = r_full;
   assign o_data  = r_data;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Write-side controller of the asynchronous FIFO. Shares the single FIFO write
// port between an ALU (2-byte result, low byte first) and the register file
// (1 byte). Each requester has a one-entry slot; the FSM serialises pending
// slots into winc/wr_data, stalls while wfull is high, and breaks ties
// round-robin using last_grant.
// Ports:
//   wclk  : write-domain clock, rising edge
//   wrst  : asynchronous active-high reset
//   bus   : fifo_wr_arbiter_if.slave (handshakes, FIFO port, busy)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  wclk,
   input  logic                  wrst,
   fifo_wr_arbiter_if.slave      bus
);

   logic [1:0]              r_state;
   logic [1:0]              w_state_next;
   logic                    r_last_grant;
   logic                    w_last_grant_next;

   logic                    w_rf_ready;
   logic                    w_rf_full;
   logic [DATA_WIDTH-1:0]   w_rf_slot;
   logic                    w_alu_ready;
   logic                    w_alu_full;
   logic [2*DATA_WIDTH-1:0] w_alu_slot;

   logic                    w_winc;
   logic                    w_rf_clear;
   logic                    w_alu_clear;
   logic                    w_rf_cand;
   logic                    w_alu_cand;
   logic                    w_grant_point;
   logic [DATA_WIDTH-1:0]   w_wr_data;

   // ---------------------------------------------------------------------
   // Holding slots
   // ---------------------------------------------------------------------
   fifo_req_slot #(
      .WIDTH   (DATA_WIDTH)
   ) u_rf_slot (
      .clk     (wclk),
      .rst     (wrst),
      .i_valid (bus.rf_valid),
      .i_data  (bus.rf_data),
      .i_clear (w_rf_clear),
      .o_ready (w_rf_ready),
      .o_full  (w_rf_full),
      .o_data  (w_rf_slot)
   );

   fifo_req_slot #(
      .WIDTH   (2*DATA_WIDTH)
   ) u_alu_slot (
      .clk     (wclk),
      .rst     (wrst),
      .i_valid (bus.alu_valid),
      .i_data  (bus.alu_data),
      .i_clear (w_alu_clear),
      .o_ready (w_alu_ready),
      .o_full  (w_alu_full),
      .o_data  (w_alu_slot)
   );

   // ---------------------------------------------------------------------
   // Write strobe and slot clearing
   // ---------------------------------------------------------------------
   // winc follows the state register directly, so an asynchronous reset
   // drops it in the same instant the state returns to IDLE.
   assign w_winc      = (r_state != ST_IDLE) && !bus.wfull;
   assign w_rf_clear  = w_winc && (r_state == ST_SEND_RF);
   assign w_alu_clear = w_winc && (r_state == ST_SEND_ALU_HI);

   // A slot emptied on this edge must not be granted again on the same edge.
   assign w_rf_cand   = w_rf_full  && !w_rf_clear;
   assign w_alu_cand  = w_alu_full && !w_alu_clear;

   // Grants are evaluated from IDLE and on the edge that completes a slot,
   // which keeps back-to-back transfers bubble-free.
   assign w_grant_point = (r_state == ST_IDLE) || (w_winc && is_last_byte(r_state));

   // ---------------------------------------------------------------------
   // FSM next-state and round-robin
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next      = r_state;
      w_last_grant_next = r_last_grant;
      if (w_grant_point) begin
         // On a tie the requester that was not granted last goes first.
         if (w_rf_cand && (!w_alu_cand || (r_last_grant == REQ_ALU))) begin
            w_state_next      = ST_SEND_RF;
            w_last_grant_next = REQ_RF;
         end else if (w_alu_cand) begin
            w_state_next      = ST_SEND_ALU_LO;
            w_last_grant_next = REQ_ALU;
         end else begin
            w_state_next      = ST_IDLE;
         end
      end else if (w_winc && (r_state == ST_SEND_ALU_LO)) begin
         w_state_next = ST_SEND_ALU_HI;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= REQ_ALU;
      end else begin
         r_state      <= w_state_next;
         r_last_grant <= w_last_grant_next;
      end
   end

   // ---------------------------------------------------------------------
   // Write data mux (holds while stalled because the state and slots hold)
   // ---------------------------------------------------------------------
   always_comb begin
      w_wr_data = '0;
      case (r_state)
         ST_SEND_RF:     w_wr_data = w_rf_slot;
         ST_SEND_ALU_LO: w_wr_data = w_alu_slot[DATA_WIDTH-1:0];
         ST_SEND_ALU_HI: w_wr_data = w_alu_slot[2*DATA_WIDTH-1:DATA_WIDTH];
         default:        w_wr_data = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.winc      = w_winc;
   assign bus.wr_data   = w_wr_data;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.rf_ready  = w_rf_ready;
   assign bus.alu_ready = w_alu_ready;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter. Expected FIFO bytes are queued when
// stimulus is driven and compared in order by a write monitor; handshake and
// timing points are checked directly by the main sequence.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   logic wclk;
   logic wrst;

   fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus ();

   fifo_wr_arbiter #(
      .DATA_WIDTH (8)
   ) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int         n_checks = 0;
   int         n_fails  = 0;
   int         n_writes = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_byte;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Write monitor: every winc cycle must match the next queued byte.
   always @(negedge wclk) begin
      if (bus.winc === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            $display("write 0x%02h (none queued)", bus.wr_data);
            check_val("spurious_winc", 32'(bus.winc), 32'd0);
         end else begin
            exp_byte = exp_q.pop_front();
            $display("write 0x%02h expected 0x%02h", bus.wr_data, exp_byte);
            check_val("wr_data", 32'(bus.wr_data), 32'(exp_byte));
         end
      end
   end

   // Present offers for one edge, then withdraw them.
   task automatic offer(input logic rf_en, input logic [7:0] rf_d,
                        input logic alu_en, input logic [15:0] alu_d);
      bus.rf_valid  = rf_en;
      bus.rf_data   = rf_d;
      bus.alu_valid = alu_en;
      bus.alu_data  = alu_d;
      @(posedge wclk);
      #1;
      bus.rf_valid  = 1'b0;
      bus.alu_valid = 1'b0;
   endtask

   // Wait (bounded) until every queued byte was written and the FSM is idle.
   task automatic wait_drain(input string tag);
      for (int i = 0; i < 100; i++) begin
         @(negedge wclk);
         if (exp_q.size() == 0 && bus.busy === 1'b0) break;
      end
      check_val(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      wrst          = 1'b0;
      bus.rf_valid  = 1'b0;
      bus.rf_data   = '0;
      bus.alu_valid = 1'b0;
      bus.alu_data  = '0;
      bus.wfull     = 1'b0;

      // ---- 1: reset asserted mid-cycle, offers ignored during reset ----
      #2 wrst = 1'b1;
      #1;
      check_val("rst_winc",      32'(bus.winc),      32'd0);
      check_val("rst_wr_data",   32'(bus.wr_data),   32'd0);
      check_val("rst_busy",      32'(bus.busy),      32'd0);
      check_val("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
      check_val("rst_rf_ready",  32'(bus.rf_ready),  32'd1);
      bus.rf_valid  = 1'b1;
      bus.rf_data   = 8'h99;
      bus.alu_valid = 1'b1;
      bus.alu_data  = 16'h9999;
      repeat (2) @(posedge wclk);
      #1;
      bus.rf_valid  = 1'b0;
      bus.alu_valid = 1'b0;
      check_val("rst_rf_ignored",  32'(bus.rf_ready),  32'd1);
      check_val("rst_alu_ignored", 32'(bus.alu_ready), 32'd1);
      wrst = 1'b0;
      repeat (3) @(negedge wclk);
      check_val("post_rst_rf_ready", 32'(bus.rf_ready), 32'd1);
      check_val("post_rst_busy",     32'(bus.busy),     32'd0);

      // ---- 2: single RF byte, 2-cycle latency ----
      w0 = n_writes;
      exp_q.push_back(8'h5A);
      offer(1'b1, 8'h5A, 1'b0, 16'h0);
      @(negedge wclk);
      check_val("rf_c1_winc",  32'(bus.winc),     32'd0);
      check_val("rf_c1_ready", 32'(bus.rf_ready), 32'd0);
      check_val("rf_c1_busy",  32'(bus.busy),     32'd0);
      @(negedge wclk);
      check_val("rf_c2_winc",  32'(bus.winc),     32'd1);
      check_val("rf_c2_ready", 32'(bus.rf_ready), 32'd0);
      @(negedge wclk);
      check_val("rf_c3_winc",  32'(bus.winc),     32'd0);
      check_val("rf_c3_ready", 32'(bus.rf_ready), 32'd1);
      check_val("rf_c3_busy",  32'(bus.busy),     32'd0);
      wait_drain("rf_drain");
      check_val("rf_write_count", 32'(n_writes - w0), 32'd1);

      // ---- 3: single ALU word, two consecutive writes ----
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      offer(1'b0, 8'h0, 1'b1, 16'h1234);
      @(negedge wclk);
      check_val("alu_c1_busy", 32'(bus.busy), 32'd0);
      @(negedge wclk);
      check_val("alu_c2_busy", 32'(bus.busy), 32'd1);
      check_val("alu_c2_winc", 32'(bus.winc), 32'd1);
      @(negedge wclk);
      check_val("alu_c3_busy", 32'(bus.busy), 32'd1);
      check_val("alu_c3_winc", 32'(bus.winc), 32'd1);
      @(negedge wclk);
      check_val("alu_c4_busy", 32'(bus.busy), 32'd0);
      check_val("alu_c4_winc", 32'(bus.winc), 32'd0);
      wait_drain("alu_drain");

      // ---- 4: ties and round-robin ----
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hBE);
      offer(1'b1, 8'hAA, 1'b1, 16'hBEEF);
      @(negedge wclk);
      for (int i = 0; i < 3; i++) begin
         @(negedge wclk);
         check_val("tie1_b2b_winc", 32'(bus.winc), 32'd1);
      end
      wait_drain("tie1_drain");

      exp_q.push_back(8'h11);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h22);
      offer(1'b1, 8'h11, 1'b1, 16'h2233);
      wait_drain("tie2_drain");

      exp_q.push_back(8'h55);
      exp_q.push_back(8'h44);
      offer(1'b0, 8'h0, 1'b1, 16'h4455);
      wait_drain("alu_only_drain");
      exp_q.push_back(8'h66);
      exp_q.push_back(8'h88);
      exp_q.push_back(8'h77);
      offer(1'b1, 8'h66, 1'b1, 16'h7788);
      wait_drain("tie3_drain");

      // ---- 5: stall on full, including between LO and HI bytes ----
      bus.wfull = 1'b1;
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      offer(1'b0, 8'h0, 1'b1, 16'h1234);
      @(negedge wclk);
      for (int i = 0; i < 5; i++) begin
         @(negedge wclk);
         check_val("full_lo_winc", 32'(bus.winc),    32'd0);
         check_val("full_lo_data", 32'(bus.wr_data), 32'h34);
      end
      @(posedge wclk);
      #1 bus.wfull = 1'b0;
      @(negedge wclk);
      check_val("rel_lo_winc", 32'(bus.winc), 32'd1);
      @(posedge wclk);
      #1 bus.wfull = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge wclk);
         check_val("full_hi_winc", 32'(bus.winc),    32'd0);
         check_val("full_hi_data", 32'(bus.wr_data), 32'h12);
      end
      @(posedge wclk);
      #1 bus.wfull = 1'b0;
      @(negedge wclk);
      check_val("rel_hi_winc", 32'(bus.winc), 32'd1);
      wait_drain("full_drain");

      // ---- 6: reset between ALU LO and HI bytes ----
      exp_q.push_back(8'hCD);   // 0xAB must never be written
      offer(1'b0, 8'h0, 1'b1, 16'hABCD);
      @(negedge wclk);
      @(negedge wclk);
      check_val("mid_lo_winc", 32'(bus.winc), 32'd1);
      @(posedge wclk);
      #1 wrst = 1'b1;
      #1;
      check_val("mid_rst_winc",  32'(bus.winc),      32'd0);
      check_val("mid_rst_busy",  32'(bus.busy),      32'd0);
      check_val("mid_rst_data",  32'(bus.wr_data),   32'd0);
      @(posedge wclk);
      #1 wrst = 1'b0;
      repeat (6) @(negedge wclk);
      check_val("mid_post_alu_ready", 32'(bus.alu_ready), 32'd1);
      check_val("mid_post_busy",      32'(bus.busy),      32'd0);

      check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
